// File: rtl/hs_collect_pkg.sv
// Shared types and sizing helpers for the round-robin handshake collector.
// HS_RR_COLLECTOR_PARITY_EN widens each FIFO entry by one parity bit.
package hs_collect_pkg;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_ACK  = 1'b1
    } ch_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // FIFO entry layout, MSB first: {parity (optional), channel, data}
    function automatic int entry_width(input int width, input int chw);
`ifdef HS_RR_COLLECTOR_PARITY_EN
        return width + chw + 1;
`else
        return width + chw;
`endif
    endfunction

endpackage

// File: rtl/hs_sync_fifo.sv
// Single-clock FIFO with a combinational head (rdata) and occupancy count.
// Pushes while full and pops while empty are ignored.
module hs_sync_fifo
    import hs_collect_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset so it can map onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/hs_rr_collector.sv
// NCH four-phase req/ack sources, round-robin admitted into a FIFO, drained to a pulse-valid port.
// Define HS_RR_COLLECTOR_PARITY_EN to add the dpar output and per-entry parity storage.
module hs_rr_collector
    import hs_collect_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int NCH   = 4,
    parameter  int DEPTH = 4,
    localparam int CHW   = (clog2(NCH) > 1) ? clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       req,
    input  logic [NCH*WIDTH-1:0] din,
    output logic [NCH-1:0]       ack,
    input  logic                 dbusy,
    output logic                 dvalid,
    output logic [WIDTH-1:0]     dout,
    output logic [CHW-1:0]       dch,
`ifdef HS_RR_COLLECTOR_PARITY_EN
    output logic                 dpar,
`endif
    output logic                 sidle
);

    localparam int EW = entry_width(WIDTH, CHW);
    localparam int AW = clog2(DEPTH);

    ch_state_e        state_q [NCH];
    ch_state_e        state_d [NCH];
    logic [WIDTH-1:0] din_ch  [NCH];
    logic [NCH-1:0]   eligible;
    logic [CHW-1:0]   rr_q;
    logic [CHW-1:0]   rr_d;
    logic             grant_vld;
    logic [CHW-1:0]   grant_ch;

    logic [EW-1:0]    fifo_wdata;
    logic [EW-1:0]    fifo_rdata;
    logic [AW:0]      fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    logic             dvalid_q;
    logic [WIDTH-1:0] dout_q;
    logic [CHW-1:0]   dch_q;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            assign din_ch[gi]   = din[gi*WIDTH +: WIDTH];
            assign eligible[gi] = (state_q[gi] == CH_IDLE) && req[gi];
            assign ack[gi]      = (state_q[gi] == CH_ACK);
        end
    endgenerate

    // Walk offsets high-to-low so the nearest eligible channel to rr_q is written last and wins.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_ch  = '0;
        idx       = 0;
        if (!fifo_full) begin
            for (int off = NCH - 1; off >= 0; off--) begin
                idx = int'(rr_q) + off;
                if (idx >= NCH) begin
                    idx = idx - NCH;
                end
                if (eligible[idx]) begin
                    grant_vld = 1'b1;
                    grant_ch  = CHW'(idx);
                end
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (grant_vld) begin
            rr_d = (grant_ch == CHW'(NCH - 1)) ? '0 : grant_ch + CHW'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                CH_IDLE: if (grant_vld && (grant_ch == CHW'(i))) state_d[i] = CH_ACK;
                CH_ACK:  if (!req[i]) state_d[i] = CH_IDLE;
                default: state_d[i] = CH_IDLE;
            endcase
        end
    end

`ifdef HS_RR_COLLECTOR_PARITY_EN
    assign fifo_wdata = {^din_ch[grant_ch], grant_ch, din_ch[grant_ch]};
`else
    assign fifo_wdata = {grant_ch, din_ch[grant_ch]};
`endif

    assign pop = !fifo_empty && !dbusy;

    hs_sync_fifo #(
        .WIDTH(EW),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (grant_vld),
        .wdata(fifo_wdata),
        .pop  (pop),
        .rdata(fifo_rdata),
        .count(fifo_count),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= CH_IDLE;
            end
            rr_q     <= '0;
            dvalid_q <= 1'b0;
            dout_q   <= '0;
            dch_q    <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
            end
            rr_q     <= rr_d;
            dvalid_q <= pop;
            if (pop) begin
                dout_q <= fifo_rdata[WIDTH-1:0];
                dch_q  <= fifo_rdata[WIDTH +: CHW];
            end
        end
    end

`ifdef HS_RR_COLLECTOR_PARITY_EN
    logic dpar_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dpar_q <= 1'b0;
        end else if (pop) begin
            dpar_q <= fifo_rdata[EW-1];
        end
    end

    assign dpar = dpar_q;
`endif

    assign dvalid = dvalid_q;
    assign dout   = dout_q;
    assign dch    = dch_q;
    assign sidle  = (fifo_count == '0) && !(|ack);

endmodule

// File: tb/tb_hs_rr_collector.sv
// Randomised and directed bench for hs_rr_collector against a queue-based behavioural model.
// Build with HS_RR_COLLECTOR_PARITY_EN to also exercise dpar.
module tb_hs_rr_collector;

    localparam int WIDTH = 32;
    localparam int NCH   = 8;
    localparam int DEPTH = 4;
    localparam int CHW   = 3;
    localparam int VW    = NCH + 1 + WIDTH + CHW + 1 + 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH-1:0]       req;
    logic [NCH*WIDTH-1:0] din;
    logic [NCH-1:0]       ack;
    logic                 dbusy;
    logic                 dvalid;
    logic [WIDTH-1:0]     dout;
    logic [CHW-1:0]       dch;
    logic                 sidle;
`ifdef HS_RR_COLLECTOR_PARITY_EN
    logic                 dpar;
`endif

    int total = 0;
    int bad   = 0;

    hs_rr_collector #(
        .WIDTH(WIDTH),
        .NCH  (NCH),
        .DEPTH(DEPTH)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .din   (din),
        .ack   (ack),
        .dbusy (dbusy),
        .dvalid(dvalid),
        .dout  (dout),
        .dch   (dch),
`ifdef HS_RR_COLLECTOR_PARITY_EN
        .dpar  (dpar),
`endif
        .sidle (sidle)
    );

    always #5 clk = ~clk;

    // Reference model: queue of pending words, per-channel "acknowledged" flag, RR pointer.
    typedef struct packed {
        logic [CHW-1:0]   ch;
        logic [WIDTH-1:0] data;
    } ent_t;

    ent_t             mq[$];
    bit               m_acked [NCH];
    int               m_rr;
    logic             m_dvalid;
    logic [WIDTH-1:0] m_dout;
    logic [CHW-1:0]   m_dch;
    logic             m_dpar;

    always @(posedge clk) begin
        int   cnt;
        int   g;
        int   c;
        ent_t e;
        if (rst) begin
            mq.delete();
            for (int i = 0; i < NCH; i++) m_acked[i] = 0;
            m_rr     = 0;
            m_dvalid = 1'b0;
            m_dout   = '0;
            m_dch    = '0;
            m_dpar   = 1'b0;
        end else begin
            cnt = mq.size();
            g   = -1;
            if (cnt < DEPTH) begin
                for (int off = 0; off < NCH; off++) begin
                    c = (m_rr + off) % NCH;
                    if (g < 0 && !m_acked[c] && req[c]) g = c;
                end
            end
            if (cnt > 0 && !dbusy) begin
                e        = mq.pop_front();
                m_dvalid = 1'b1;
                m_dout   = e.data;
                m_dch    = e.ch;
                m_dpar   = ^e.data;
            end else begin
                m_dvalid = 1'b0;
            end
            for (int i = 0; i < NCH; i++) begin
                if (m_acked[i] && !req[i]) m_acked[i] = 0;
            end
            if (g >= 0) begin
                e.ch   = CHW'(g);
                e.data = din[g*WIDTH +: WIDTH];
                mq.push_back(e);
                m_acked[g] = 1;
                m_rr       = (g + 1) % NCH;
            end
        end
    end

    function automatic logic [VW-1:0] obs_vec();
        logic p;
        p = 1'b0;
`ifdef HS_RR_COLLECTOR_PARITY_EN
        p = dpar;
`endif
        return {ack, dvalid, dout, dch, sidle, p};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [NCH-1:0] a;
        logic           p;
        logic           idle;
        p    = 1'b0;
        idle = (mq.size() == 0);
        for (int i = 0; i < NCH; i++) begin
            a[i] = m_acked[i];
            if (m_acked[i]) idle = 1'b0;
        end
`ifdef HS_RR_COLLECTOR_PARITY_EN
        p = m_dpar;
`endif
        return {a, m_dvalid, m_dout, m_dch, idle, p};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Four-phase source behaviour: drop req after ack, raise again only once ack is low.
    task automatic drive_sources(input int p_raise, input int p_drop);
        for (int c = 0; c < NCH; c++) begin
            if (req[c] && ack[c]) begin
                if ($urandom_range(99) < p_drop) req[c] = 1'b0;
                din[c*WIDTH +: WIDTH] = $urandom;
            end else if (!req[c] && !ack[c]) begin
                if ($urandom_range(99) < p_raise) begin
                    req[c] = 1'b1;
                    din[c*WIDTH +: WIDTH] = $urandom;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; din = '0; dbusy = 1'b0;
        @(negedge clk);
        tick();
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL reset_vec got=%h want=%h", obs_vec(), exp_vec());
        end
        total++;
        if (ack !== '0 || dvalid !== 1'b0 || dout !== '0 || dch !== '0 || sidle !== 1'b1) begin
            bad++;
            $display("FAIL reset_outputs got ack=%h dvalid=%b dout=%h dch=%0d sidle=%b want 0/0/0/0/1",
                     ack, dvalid, dout, dch, sidle);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        for (int i = 0; i < 3; i++) tick();
        din[2*WIDTH +: WIDTH] = 32'hDEADBEEF;
        req[2] = 1'b1;
        tick();
        total++;
        if (ack[2] !== 1'b1 || dvalid !== 1'b0 || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL single_ack got ack=%h dvalid=%b want ack[2]=1 dvalid=0", ack, dvalid);
        end
        tick();
        total++;
        if (dvalid !== 1'b1 || dout !== 32'hDEADBEEF || dch !== 3'd2 || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL single_deliver got dvalid=%b dout=%h dch=%0d want 1/deadbeef/2", dvalid, dout, dch);
        end
        req[2] = 1'b0;
        tick();
        total++;
        if (ack[2] !== 1'b0 || sidle !== 1'b1 || dvalid !== 1'b0 || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL single_release got ack=%h sidle=%b dvalid=%b want 0/1/0", ack, sidle, dvalid);
        end
    endtask

    task automatic test_rr();
        int prev;
        prev = -1;
        dbusy = 1'b0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            drive_sources(100, 100);
            tick();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL rr_vec cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
            end
            if (dvalid === 1'b1) begin
                if (prev >= 0) begin
                    total++;
                    if (dch !== CHW'((prev + 1) % NCH)) begin
                        bad++;
                        $display("FAIL rr_order cyc=%0d got dch=%0d want %0d", cyc, dch, (prev + 1) % NCH);
                    end
                end
                prev = int'(dch);
            end
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            drive_sources(0, 100);
            tick();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL rr_drain_vec cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_backpressure();
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        dbusy = 1'b1;
        for (int c = 0; c < 6; c++) begin
            din[c*WIDTH +: WIDTH] = $urandom;
            req[c] = 1'b1;
        end
        for (int cyc = 0; cyc < 8; cyc++) begin
            tick();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL bp_fill_vec cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
            end
        end
        total++;
        if (ack !== 8'h0F || dvalid !== 1'b0) begin
            bad++;
            $display("FAIL bp_full_acks got ack=%h dvalid=%b want ack=0f dvalid=0", ack, dvalid);
        end
        dbusy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            total++;
            if (dvalid !== 1'b1 || dch !== CHW'(k) || obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL bp_drain k=%0d got dvalid=%b dch=%0d want 1/%0d", k, dvalid, dch, k);
            end
            if (k < 2) begin
                total++;
                if (ack[4] !== ((k == 1) ? 1'b1 : 1'b0)) begin
                    bad++;
                    $display("FAIL bp_pop_at_full k=%0d got ack[4]=%b want %0d", k, ack[4], k);
                end
            end
        end
        req = '0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            tick();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL bp_release_vec cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] d1;
        dbusy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            din[c*WIDTH +: WIDTH] = $urandom;
            req[c] = 1'b1;
        end
        for (int cyc = 0; cyc < 3; cyc++) tick();
        total++;
        if (ack[2:0] !== 3'b111 || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL mid_setup got ack=%h want ack[2:0]=111", ack);
        end
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
        total++;
        if (ack !== '0 || dvalid !== 1'b0 || dout !== '0 || sidle !== 1'b1 || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL mid_reset got ack=%h dvalid=%b dout=%h sidle=%b want 0/0/0/1", ack, dvalid, dout, sidle);
        end
        dbusy = 1'b0;
        d1 = $urandom;
        din[1*WIDTH +: WIDTH] = d1;
        req[1] = 1'b1;
        tick();
        total++;
        if (ack[1] !== 1'b1 || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL mid_after_ack got ack=%h want ack[1]=1", ack);
        end
        tick();
        total++;
        if (dvalid !== 1'b1 || dch !== 3'd1 || dout !== d1 || obs_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL mid_after_data got dvalid=%b dch=%0d dout=%h want 1/1/%h", dvalid, dch, dout, d1);
        end
        req[1] = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            dbusy = ($urandom_range(99) < 40);
            drive_sources(30, 60);
            tick();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random_vec cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
            end
        end
        dbusy = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            drive_sources(0, 100);
            tick();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random_drain_vec cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
            end
        end
        total++;
        if (sidle !== 1'b1) begin
            bad++;
            $display("FAIL random_idle got sidle=%b want 1", sidle);
        end
    endtask

`ifdef HS_RR_COLLECTOR_PARITY_EN
    task automatic test_parity();
        logic [WIDTH-1:0] vals [2];
        logic             want [2];
        vals[0] = 32'h00000007; want[0] = 1'b1;
        vals[1] = 32'h00000003; want[1] = 1'b0;
        dbusy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            din[3*WIDTH +: WIDTH] = vals[k];
            req[3] = 1'b1;
            tick();
            tick();
            total++;
            if (dvalid !== 1'b1 || dout !== vals[k] || dpar !== want[k] || obs_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL parity din=%h got dvalid=%b dpar=%b want 1/%b", vals[k], dvalid, dpar, want[k]);
            end
            req[3] = 1'b0;
            tick();
            tick();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef HS_RR_COLLECTOR_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hs_rr_collector.md
Name: hs_rr_collector

Overview:
- Single-clock collector: NCH independent four-phase req/ack source channels feed one pulse-valid destination port.
- Round-robin arbitration admits at most one capture per cycle into an internal DEPTH-entry FIFO that holds {channel, data}.
- The FIFO drains one entry per cycle whenever the destination is not busy.
- Next-generation, multi-channel, buffered successor of the team's single-channel handshake block; sits between compute lanes and a shared output stage.

Parameters:
- WIDTH, 32, data width per channel.
- NCH, 4, number of source channels (2..16).
- DEPTH, 4, FIFO entries (power of two, >=2).
- CHW, derived = max(1, clog2(NCH)), channel-index width. Local only, not overridable.

Ports:
- clk  in  1  Single clock for the whole block; all logic on its rising edge.
- rst  in  1  Reset. Synchronous, active-high.
- req  in  NCH  Per-channel four-phase request.
- din  in  NCH*WIDTH  Per-channel data; channel i occupies bits [i*WIDTH +: WIDTH]. Must be stable while req[i]=1 and ack[i]=0.
- ack  out  NCH  Per-channel acknowledge, registered.
- dbusy  in  1  Destination busy; no pop while high.
- dvalid  out  1  One-cycle pulse per delivered word, registered.
- dout  out  WIDTH  Delivered data, registered.
- dch  out  CHW  Source channel of dout, registered.
- sidle  out  1  High when FIFO is empty and every channel FSM is CH_IDLE, combinational.

Behaviour:
- Reset (rst=1 at a clk edge), all registers cleared:
  - ack=0, dvalid=0, dout=0, dch=0, FIFO count=0.
  - RR pointer=0; all channel FSMs to CH_IDLE.
  - Reset mid-transfer drops any FIFO contents and in-flight ack.
- Per-channel FSM, states CH_IDLE and CH_ACK:
  - CH_IDLE, eligible when req[i]=1. If granted: capture din[i] into the FIFO, ack[i]<=1, go to CH_ACK.
  - CH_ACK: hold ack[i]=1 until req[i] is sampled 0; then ack[i]<=0 and return to CH_IDLE.
  - A new request is only considered once req[i]=1 is sampled in CH_IDLE, i.e. at least one cycle after ack[i] falls.
- Arbitration:
  - Grant only if FIFO count<DEPTH, evaluated before this cycle's pop. No push-on-full even if a pop occurs the same cycle.
  - Search starts at the RR pointer and wraps modulo NCH; the first eligible channel wins.
  - After a grant to channel g, pointer <= (g+1) mod NCH. With no grant the pointer holds.
- Latency:
  - req[i] sampled high at edge k with grant: ack[i]=1 and the entry is in the FIFO after edge k.
  - Earliest dvalid=1 is after edge k+1, given dbusy=0 at k+1.
- Pop rule:
  - At each edge, if count>0 and dbusy=0: pop head; dvalid<=1, dout<=data, dch<=channel.
  - Otherwise dvalid<=0, and dout/dch hold their last values.
  - Back-to-back pops give consecutive dvalid pulses.
- Simultaneous push and pop: count is unchanged, pointers advance. Ordering is strict FIFO, so dout order equals grant order.
- Full FIFO: eligible channels stay in CH_IDLE with ack=0 and no data loss. The RR pointer does not move.
- Pointer wrap: FIFO read/write pointers are clog2(DEPTH) bits and wrap naturally.
- din sampling: data is sampled only on the grant edge; din changes afterwards are ignored.

Optional Feature:
- Macro: HS_RR_COLLECTOR_PARITY_EN.
- Defined:
  - Each FIFO entry stores an extra even-parity bit computed at capture (^din[i]).
  - Extra output port dpar (1 bit, out) is registered alongside dout on pop and holds otherwise.
  - Reset value of dpar is 0.
- Undefined: no dpar port, no parity storage; FIFO entry width is WIDTH+CHW.

Decomposition:
- Package hs_collect_pkg holds:
  - channel-state encodings CH_IDLE=1'b0 and CH_ACK=1'b1;
  - a clog2 helper function;
  - the FIFO-entry width rule (WIDTH+CHW, +1 with parity).
- One sub-module, hs_sync_fifo:
  - parameters WIDTH, DEPTH;
  - ports clk, rst, push, wdata, pop, rdata, count, full, empty;
  - synchronous active-high reset;
  - rdata is the combinational head.
- Arbiter and channel FSMs stay in the top level.

Test Plan:
- Single transfer:
  - Stimulus: reset; din[2]=32'hDEADBEEF, req[2]=1 at cycle 5.
  - Response: ack[2]=1 after edge 5; dvalid=1, dout=32'hDEADBEEF, dch=2 after edge 6; ack[2] falls one cycle after req[2] drops; sidle returns to 1.
- Round-robin fairness:
  - Stimulus: all 4 req high continuously, each re-asserted as soon as ack falls, dbusy=0.
  - Response: grant order 0,1,2,3,0,1…; dch sequence matches; no channel granted twice within 4 grants.
- Full / backpressure:
  - Stimulus: dbusy=1; 6 channels' worth of requests (NCH=8, DEPTH=4).
  - Response: exactly 4 acks rise and the others stay 0. After dbusy=0, 4 consecutive dvalid pulses in grant order, then the remaining channels are granted.
- Simultaneous push/pop at full:
  - Stimulus: count=4, dbusy=0, one eligible req.
  - Response: pop occurs and no grant that cycle; grant on the next edge (count=3<4).
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle while count=3 and ack[1]=1.
  - Response: after the edge, ack=0, dvalid=0, dout=0, count=0, sidle=1; a subsequent req[1] is served normally.
- Parity (macro defined):
  - Stimulus: din=32'h00000007.
  - Response: dpar=1 with dvalid; for din=32'h00000003, dpar=0.
